// File: rtl/noc_params.sv
// noc_params: shared NoC constants, flit label encoding and flit structure
package noc_params;
    localparam int VC_NUM      = 2;
    localparam int VC_SIZE     = $clog2(VC_NUM);
    localparam int PORT_NUM    = 5;
    localparam int DATA_SIZE   = 16;
    localparam int FLOW_ON_OFF = 0;
    localparam int FLOW_CREDIT = 1;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef struct packed {
        flit_label_t            label;
        logic [VC_SIZE-1:0]     vc_id;
        logic [DATA_SIZE-1:0]   data;
    } flit_t;
endpackage

// File: rtl/output_port_flow_ctrl_vc_credit_counter.sv
// vc_credit_counter: per-VC downstream credit count with saturation and overflow detection
module vc_credit_counter #(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          send,
    input  logic          credit,
    output logic [CW-1:0] cnt,
    output logic          overflow
);
    assign overflow = en && credit && !send && cnt == CW'(DEPTH);

    // count down on send, up on returned credit; pinned at DEPTH when flow control is not credit based
    always_ff @(posedge clk) begin
        if (!rst || !en) cnt <= CW'(DEPTH);
        else if (!overflow) cnt <= cnt - CW'(send) + CW'(credit);
    end
endmodule

// File: rtl/output_port_flow_ctrl.sv
// output_port_flow_ctrl: registered output link stage with credit or on/off flow control, busy tracking and error flags
module output_port_flow_ctrl
    import noc_params::*;
#(
    parameter int VC_NUM_P    = VC_NUM,
    parameter int DEPTH       = 8,
    parameter int CREDIT_MODE = FLOW_CREDIT,
    parameter int ON_OFF_REG  = 1,
    localparam int VS = VC_NUM_P > 1 ? $clog2(VC_NUM_P) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  flit_t               flit_i,
    input  logic                valid_i,
    input  logic [VS-1:0]       vc_sel_i,
    input  logic [VC_NUM_P-1:0] credit_i,
    input  logic [VC_NUM_P-1:0] on_off_i,
    output flit_t               data_o,
    output logic                is_valid_o,
    output logic [VC_NUM_P-1:0] can_send_o,
    output logic [VC_NUM_P-1:0] vc_idle_o,
    output logic [VC_NUM_P-1:0] error_o
);
    localparam logic CREDIT_EN = CREDIT_MODE == FLOW_CREDIT;

    logic [VC_NUM_P-1:0] on_off_q, on_off_eff, send, busy, busy_nxt, err_nxt, ovf;
    logic [CW-1:0]       cnt [VC_NUM_P];

    assign on_off_eff = ON_OFF_REG != 0 ? on_off_q : on_off_i;

    genvar v;
    generate
        for (v = 0; v < VC_NUM_P; v++) begin : g_vc
            vc_credit_counter #(.DEPTH(DEPTH)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .en       (CREDIT_EN),
                .send     (send[v]),
                .credit   (credit_i[v]),
                .cnt      (cnt[v]),
                .overflow (ovf[v])
            );
            assign can_send_o[v] = CREDIT_EN ? cnt[v] != '0 : on_off_eff[v];
            assign send[v]       = valid_i && vc_sel_i == VS'(v) && can_send_o[v];
            assign vc_idle_o[v]  = !busy[v] && (!CREDIT_EN || cnt[v] == CW'(DEPTH));
        end
    endgenerate

    // packet framing per VC: HEAD opens, TAIL closes, out-of-order labels and refused sends are errors
    always_comb begin
        busy_nxt = busy;
        err_nxt  = error_o | ovf;
        for (int i = 0; i < VC_NUM_P; i++) begin
            if (valid_i && vc_sel_i == VS'(i) && !can_send_o[i]) err_nxt[i] = 1'b1;
            if (send[i]) begin
                if ((flit_i.label == HEAD && busy[i]) ||
                    ((flit_i.label == BODY || flit_i.label == TAIL) && !busy[i])) err_nxt[i] = 1'b1;
                busy_nxt[i] = flit_i.label == HEAD || (flit_i.label == BODY && busy[i]);
            end
        end
    end

    // link register, framing state, sticky errors and sampled on/off
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_o     <= '0;
            is_valid_o <= 1'b0;
            busy       <= '0;
            error_o    <= '0;
            on_off_q   <= '1;
        end else begin
            is_valid_o <= |send;
            if (|send) data_o <= flit_i;
            busy       <= busy_nxt;
            error_o    <= err_nxt;
            on_off_q   <= on_off_i;
        end
    end
endmodule
